// File: rtl/conv_seq_pkg.sv
// Shared encodings for the convolution command sequencer: GPIO command codes,
// FSM states and kernel geometry.
package conv_seq_pkg;

    localparam logic [2:0] CMD_KERNEL    = 3'b000;
    localparam logic [2:0] CMD_LEN       = 3'b001;
    localparam logic [2:0] CMD_LOAD      = 3'b010;
    localparam logic [2:0] CMD_LOAD_LAST = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b011;

    localparam int KERNEL_ROWS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_READ = 2'd3
    } state_t;

endpackage

// File: rtl/conv_seq_ctrl_edge_det.sv
// Rising-edge detector for the GPIO valid strobe; one-cycle pulse per 0->1 transition.
module gpio_edge_det (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_edge
);

    logic r_vld_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_vld_d <= 1'b0;
        else         r_vld_d <= i_valid;
    end

    assign o_edge = i_valid & ~r_vld_d;

endmodule

// File: rtl/conv_seq_ctrl.sv
// GPIO command sequencer for the 2D convolver: kernel/length load, column streaming,
// convolver start and result readout. Define SEQ_PROTO_ERR_EN for the sticky protocol-error flag.
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int N       = 2,
    parameter int NB_PIX  = 8,
    parameter int NB_ADDR = 10,
    parameter int NB_OUT  = 13,
    localparam int MW     = $clog2(N + 2),
    localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [23:0]         i_GPIOdata,
    input  logic [2:0]          i_GPIOctrl,
    input  logic                i_GPIOvalid,
    output logic [NB_OUT:0]     o_GPIOdata,
    output logic                o_led,
    output logic                o_kernel_we,
    output logic [1:0]          o_kernel_row,
    output logic [23:0]         o_kernel_data,
    output logic [N+1:0]        o_mem_we,
    output logic [NB_ADDR-1:0]  o_mem_addr,
    output logic [NB_PIX-1:0]   o_mem_data,
    output logic [NB_ADDR-1:0]  o_img_len,
    output logic [MW-1:0]       o_mem_base,
    output logic                o_conv_start,
    input  logic                i_conv_done,
    output logic [SW-1:0]       o_res_sel,
    output logic [NB_ADDR-1:0]  o_res_addr,
    input  logic [NB_OUT-1:0]   i_res_data
);

    state_t               r_state, w_next;
    logic                 w_edge, w_is_load, w_is_last;
    logic                 w_kernel_wr, w_load_wr, w_load_last, w_abort;
    logic                 w_done_run, w_read_step, w_read_end;
    logic [1:0]           r_k_idx;
    logic [MW-1:0]        r_wr_mem, w_wr_mem_inc;
    logic [NB_ADDR-1:0]   r_wr_addr, w_rd_last;
    logic                 r_start_pend, w_err;
    logic [N+1:0]         w_onehot;

    gpio_edge_det u_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_GPIOvalid),
        .o_edge  (w_edge)
    );

    assign w_is_load    = (i_GPIOctrl == CMD_LOAD) || (i_GPIOctrl == CMD_LOAD_LAST);
    assign w_is_last    = (i_GPIOctrl == CMD_LOAD_LAST);
    assign w_rd_last    = o_img_len - NB_ADDR'(2);
    assign w_wr_mem_inc = (r_wr_mem == MW'(N + 1)) ? '0 : r_wr_mem + 1'b1;
    assign w_onehot     = (N + 2)'(1) << r_wr_mem;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_kernel_wr = 1'b0;
        w_load_wr   = 1'b0;
        w_load_last = 1'b0;
        w_abort     = 1'b0;
        w_done_run  = 1'b0;
        w_read_step = 1'b0;
        w_read_end  = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                w_kernel_wr = w_edge && (i_GPIOctrl == CMD_KERNEL);
                if (w_edge && w_is_load) begin
                    w_load_wr   = 1'b1;
                    w_load_last = w_is_last;
                    w_next      = w_is_last ? ST_RUN : ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_conv_done) begin
                    w_done_run = 1'b1;
                    w_next     = ST_READ;
                end
            end
            ST_READ: begin
                // A load during readout abandons the remaining results
                if (w_edge && w_is_load) begin
                    w_abort     = 1'b1;
                    w_load_wr   = 1'b1;
                    w_load_last = w_is_last;
                    w_next      = w_is_last ? ST_RUN : ST_LOAD;
                end else if (w_edge && (i_GPIOctrl == CMD_READ)) begin
                    w_read_step = 1'b1;
                    w_read_end  = (o_res_sel == SW'(N - 1)) && (o_res_addr == w_rd_last);
                    if (w_read_end) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_kernel_we   <= 1'b0;
            o_kernel_row  <= '0;
            o_kernel_data <= '0;
            r_k_idx       <= '0;
            o_img_len     <= '0;
            o_mem_we      <= '0;
            o_mem_addr    <= '0;
            o_mem_data    <= '0;
            r_wr_mem      <= '0;
            r_wr_addr     <= '0;
            r_start_pend  <= 1'b0;
            o_conv_start  <= 1'b0;
            o_mem_base    <= '0;
            o_led         <= 1'b0;
            o_res_sel     <= '0;
            o_res_addr    <= '0;
        end else begin
            o_kernel_we <= w_kernel_wr;
            if (w_kernel_wr) begin
                o_kernel_row  <= r_k_idx;
                o_kernel_data <= i_GPIOdata;
                r_k_idx       <= (r_k_idx == 2'(KERNEL_ROWS - 1)) ? 2'd0 : r_k_idx + 2'd1;
            end
            if (i_GPIOctrl == CMD_LEN) o_img_len <= i_GPIOdata[NB_ADDR-1:0];

            o_mem_we <= w_load_wr ? w_onehot : '0;
            if (w_load_wr) begin
                o_mem_addr <= r_wr_addr;
                o_mem_data <= i_GPIOdata[NB_PIX-1:0];
                if (r_wr_addr == o_img_len) begin
                    r_wr_addr <= '0;
                    r_wr_mem  <= w_wr_mem_inc;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end

            // Start follows the final write so the base reflects the advanced pointer
            r_start_pend <= w_load_last;
            o_conv_start <= r_start_pend;
            if (r_start_pend) o_mem_base <= r_wr_mem;

            if (w_done_run) begin
                o_led      <= 1'b1;
                o_res_sel  <= '0;
                o_res_addr <= '0;
            end else if (w_abort) begin
                o_led <= 1'b0;
            end else if (w_read_step) begin
                if (w_read_end) begin
                    o_led      <= 1'b0;
                    o_res_sel  <= '0;
                    o_res_addr <= '0;
                end else if (o_res_addr == w_rd_last) begin
                    o_res_addr <= '0;
                    o_res_sel  <= o_res_sel + 1'b1;
                end else begin
                    o_res_addr <= o_res_addr + 1'b1;
                end
            end
        end
    end

`ifdef SEQ_PROTO_ERR_EN
    logic          r_first, r_err, w_col_done, w_full, w_err_set;
    logic [MW:0]   r_batch_cnt, w_target;

    assign w_target   = r_first ? (MW + 1)'(N + 2) : (MW + 1)'(N);
    assign w_col_done = w_load_wr && (r_wr_addr == o_img_len);
    assign w_full     = (r_batch_cnt == w_target);
    assign w_err_set  = (w_load_wr && !w_load_last && w_full)
                     || (w_load_last && !(w_col_done && (r_batch_cnt == w_target - 1'b1)))
                     || (w_edge && (i_GPIOctrl == CMD_KERNEL) && (r_state == ST_READ))
                     || (w_edge && (r_state == ST_RUN))
                     || w_abort;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_first     <= 1'b1;
            r_err       <= 1'b0;
            r_batch_cnt <= '0;
        end else begin
            if (w_err_set) r_err <= 1'b1;
            if (w_load_last) begin
                r_first     <= 1'b0;
                r_batch_cnt <= '0;
            end else if (w_col_done && !w_full) begin
                r_batch_cnt <= r_batch_cnt + 1'b1;
            end
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign o_GPIOdata = {w_err, (r_state == ST_READ) ? i_res_data : {NB_OUT{1'b0}}};

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Command sequencer between the MicroBlaze GPIO word and the 2D convolution datapath. It decodes the GPIO control field and loads the 3x3 kernel and the image length. It streams image columns into the rotating bank of N+2 column memories, starts the convolver and flags completion on the LED. It then steps the MicroBlaze through the N result memories.

## Interface
- `N`, 2: output columns per batch; N+2 column memories.
- `NB_PIX`, 8: pixel width, taken from `i_GPIOdata[NB_PIX-1:0]`.
- `NB_ADDR`, 10: column memory address width.
- `NB_OUT`, 13: convolution result width.
- `i_clock`  in  1  system clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_GPIOdata`  in  24  GPIO payload.
- `i_GPIOctrl`  in  3  command: 000 KERNEL, 001 LEN, 010 LOAD, 100 LOAD_LAST, 011 READ; all other codes are ignored.
- `i_GPIOvalid`  in  1  level strobe; only the rising edge acts.
- `o_GPIOdata`  out  NB_OUT+1  `{err, result}` returned to GPIO.
- `o_led`  out  1  results ready.
- `o_kernel_we`, `o_kernel_row[1:0]`, `o_kernel_data[23:0]`  out  kernel row write.
- `o_mem_we`  out  N+2  one-hot column memory write enable.
- `o_mem_addr`  out  NB_ADDR  column memory write address.
- `o_mem_data`  out  NB_PIX  column memory write data.
- `o_img_len`  out  NB_ADDR  last row index L.
- `o_mem_base`  out  clog2(N+2)  memory holding the oldest window column.
- `o_conv_start`  out  1  one-cycle start pulse.
- `i_conv_done`  in  1  one-cycle done pulse from the convolver.
- `o_res_sel`  out  clog2(N)  selects the result memory.
- `o_res_addr`  out  NB_ADDR  result read address.
- `i_res_data`  in  NB_OUT  result read data (1-cycle RAM latency).

## Operation
- Edge detection: `vld_d` holds the registered `i_GPIOvalid`. `edge = i_GPIOvalid & ~vld_d`. Each command acts once per edge.
- KERNEL edge: write `i_GPIOdata` to row `k_idx`, then advance `k_idx`. `k_idx` runs 0, 1, 2 and wraps to 0.
- LEN is level-sensitive. While ctrl == 001, `o_img_len <= i_GPIOdata[NB_ADDR-1:0]` every cycle; no valid edge is needed.
- Each column memory receives L+1 pixels at addresses 0..L.
- A batch loads N+2 memories when the `first` flag is set, otherwise N memories.
- LOAD / LOAD_LAST edge:
  - write the pixel to memory `wr_mem` at `wr_addr`;
  - when `wr_addr == L`, set `wr_addr` to 0 and `wr_mem` to (wr_mem+1) mod (N+2);
  - otherwise increment `wr_addr`.
- LOAD_LAST edge: perform the write, then go to RUN.
  - The cycle after the write, `o_mem_base <= wr_mem` (the post-advance value) and `o_conv_start` pulses.
  - `first` clears.
- RUN: on `i_conv_done`, set `o_led`. Clear `rd_sel` and `rd_addr`, then go to READ.
- READ: `o_GPIOdata[NB_OUT-1:0] = i_res_data` for the current (`rd_sel`, `rd_addr`).
  - Each READ edge advances `rd_addr` over 0..L-2.
  - At L-2, `rd_addr` returns to 0 and `rd_sel` increments.
  - The edge after the last word (read N*(L-1)) clears `o_led` and returns to IDLE.
- FSM states: IDLE → LOAD (first LOAD edge) → RUN (LOAD_LAST) → READ (`i_conv_done`) → IDLE (readout finished).
- KERNEL is accepted only in IDLE and LOAD.
- LOAD or LOAD_LAST edge in READ: abort the readout, clear `o_led`, and process the edge as a load in the same cycle.
- Any edge in RUN is ignored.
- Reset values, for every output and register: all outputs 0, `first` = 1, all pointers 0, `o_img_len` = 0, state IDLE. A reset in mid-operation discards the current batch.

## Timing
- Memory and kernel write strobes, address and data are registered one cycle after the edge cycle. `o_mem_we` and `o_kernel_we` are one cycle wide.
- `o_conv_start` is asserted 2 cycles after the LOAD_LAST edge cycle.
- `o_led` rises 1 cycle after `i_conv_done`.
- `o_res_addr` and `o_res_sel` update 1 cycle after a READ edge. `o_GPIOdata` is valid 2 cycles after the edge.
- GPIO inputs are in the `i_clock` domain; no synchroniser.

## Configuration
- `SEQ_PROTO_ERR_EN`: compiles in a sticky protocol-error flag on `o_GPIOdata[NB_OUT]`.
- The flag sets on any of:
  - LOAD_LAST when the pixel written is not address L of the batch's last memory;
  - a LOAD edge after the batch is already full;
  - a KERNEL edge outside IDLE/LOAD;
  - an edge in RUN;
  - a readout aborted by a load.
- The flag clears only on reset.
- Without the macro, `o_GPIOdata[NB_OUT]` is tied to 0 and no error logic is built.

## Structure
- A shared package `conv_seq_pkg` holds the command encodings (`CMD_KERNEL`, `CMD_LEN`, `CMD_LOAD`, `CMD_LOAD_LAST`, `CMD_READ`), the FSM state encodings and `KERNEL_ROWS = 3`.
- One sub-module, `gpio_edge_det`: registers `i_GPIOvalid` and emits a one-cycle edge pulse.

## Test plan
- Kernel: KERNEL edges with 0x002000, 0x208020, 0x002000 → three `o_kernel_we` pulses on rows 0, 1, 2 with matching data. A fourth edge → row 0.
- LEN: ctrl = 001, data 15, no valid → `o_img_len` = 15 after 1 cycle.
- First batch: L = 15, N = 2, 64 load edges, the last with ctrl 100.
  - Required response: 16 writes per memory, one-hot 0001→1000.
  - `o_mem_base` = 0; one `o_conv_start`; err = 0.
- Second batch: 32 load edges.
  - Required response: memories 0 then 1; `o_mem_base` = 2; `first` stays 0.
- Readout: pulse `i_conv_done` → `o_led` = 1.
  - 28 READ edges → `o_res_sel`/`o_res_addr` step (0,0..13), then (1,0..13).
  - The 28th edge → `o_led` = 0, state IDLE.
- Error and reset: LOAD_LAST after 5 pixels → conv start and err = 1 (macro on) or 0 (macro off).
  - `i_reset` mid-load → all outputs 0 and `first` = 1; the next batch writes memory 0 from address 0.
